// File: rtl/spike_decode_pkg.sv
// ---------------------------------------------------------------------------
// spike_decode_pkg
// Shared definitions for the spike rate/latency decoder:
//   WINDOW_W_DEF / COUNT_W_DEF : default widths of window index and spike count
//   TTFS_NONE                  : latency code meaning "no spike in window"
//   rate_result_t              : decoded result {count, ttfs} at default widths
//   dec_state_e                : decoder mode (IDLE when disabled, COUNT when enabled)
// ---------------------------------------------------------------------------
package spike_decode_pkg;

    localparam int unsigned WINDOW_W_DEF = 8;
    localparam int unsigned COUNT_W_DEF  = 8;

    localparam logic [WINDOW_W_DEF-1:0] TTFS_NONE = '1;

    typedef struct packed {
        logic [COUNT_W_DEF-1:0]  count;
        logic [WINDOW_W_DEF-1:0] ttfs;
    } rate_result_t;

    typedef enum logic {
        ST_IDLE,
        ST_COUNT
    } dec_state_e;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that holds at all-ones instead of wrapping.
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   clear_i      : synchronous clear (applied after this cycle's increment is seen
//                  on count_next_o)
//   inc_i        : add one this cycle
//   count_o      : registered count
//   count_next_o : saturated count including this cycle's increment
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_next_o = count_q;
        if (inc_i && (count_q != '1)) begin
            count_next_o = count_q + 1'b1;
        end
        count_d = clear_i ? '0 : count_next_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
// Decodes a 1-bit spike stream over windows of N = window+1 enabled cycles into
// a saturating spike count (rate code) and time-to-first-spike (latency code),
// delivered through a valid/ready result register with a sticky overrun flag.
//   clk           : clock, rising edge
//   reset         : synchronous active-high reset
//   enable        : decode enable; low discards the partial window
//   spike         : spike input, sampled every enabled cycle
//   window        : window length minus one
//   rate_ready    : consumer accepts the pending result
//   clear_overrun : clears the sticky overrun flag
//   rate_valid    : result register holds an unconsumed result
//   rate_count    : spike count of the last completed window (saturated)
//   rate_ttfs     : cycle index of the first spike, all-ones if none
//   overrun       : sticky, an unconsumed result was overwritten
// ---------------------------------------------------------------------------
module spike_rate_decoder
    import spike_decode_pkg::*;
#(
    parameter int unsigned WINDOW_W = WINDOW_W_DEF,
    parameter int unsigned COUNT_W  = COUNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                spike,
    input  logic [WINDOW_W-1:0] window,
    input  logic                rate_ready,
    input  logic                clear_overrun,
    output logic                rate_valid,
    output logic [COUNT_W-1:0]  rate_count,
    output logic [WINDOW_W-1:0] rate_ttfs,
    output logic                overrun
);

    typedef struct packed {
        logic [COUNT_W-1:0]  count;
        logic [WINDOW_W-1:0] ttfs;
    } result_t;

    dec_state_e          state_q, state_d;
    logic [WINDOW_W-1:0] cyc_q, cyc_d, cyc_idx;
    logic                seen_q, seen_d;
    logic [WINDOW_W-1:0] ttfs_q, ttfs_d, ttfs_now;
    result_t             res_q, res_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                cnt_clear, capture;
    logic [COUNT_W-1:0]  cnt_now;
    logic [COUNT_W-1:0]  cnt_unused;

    sat_counter #(
        .W (COUNT_W)
    ) u_cnt (
        .clk_i        (clk),
        .rst_i        (reset),
        .clear_i      (cnt_clear),
        .inc_i        (enable & spike),
        .count_o      (cnt_unused),
        .count_next_o (cnt_now)
    );

    always_comb begin
        state_d   = enable ? ST_COUNT : ST_IDLE;
        cyc_d     = cyc_q;
        seen_d    = seen_q;
        ttfs_d    = ttfs_q;
        cnt_clear = 1'b0;
        capture   = 1'b0;
        res_d     = res_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;

        // The first enabled cycle after IDLE is always index 0.
        cyc_idx  = (state_q == ST_COUNT) ? cyc_q : '0;
        ttfs_now = seen_q ? ttfs_q : (spike ? cyc_idx : '1);

        if (!enable) begin
            cyc_d     = '0;
            seen_d    = 1'b0;
            ttfs_d    = '1;
            cnt_clear = 1'b1;
        end else if (cyc_idx >= window) begin
            // >= lets a window shrunk below the current index end right here.
            capture   = 1'b1;
            cyc_d     = '0;
            seen_d    = 1'b0;
            ttfs_d    = '1;
            cnt_clear = 1'b1;
        end else begin
            cyc_d  = cyc_idx + 1'b1;
            seen_d = seen_q | spike;
            ttfs_d = ttfs_now;
        end

        if (capture) begin
            res_d.count = cnt_now;
            res_d.ttfs  = ttfs_now;
            valid_d     = 1'b1;
        end else if (valid_q && rate_ready) begin
            valid_d = 1'b0;
        end

        // Overwrite of an unaccepted result wins over a same-cycle clear.
        if (capture && valid_q && !rate_ready) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            seen_q  <= 1'b0;
            ttfs_q  <= '1;
            res_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            seen_q  <= seen_d;
            ttfs_q  <= ttfs_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rate_valid = valid_q;
    assign rate_count = res_q.count;
    assign rate_ttfs  = res_q.ttfs;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_decoder
// Drives two decoders (default widths and COUNT_W=3) with identical stimulus and
// compares both against a window-buffer reference model every cycle.
// ---------------------------------------------------------------------------
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       reset, enable, spike, rate_ready, clear_overrun;
    logic [7:0] window;
    logic       rate_valid, overrun, rate_valid_s, overrun_s;
    logic [7:0] rate_count, rate_ttfs, rate_ttfs_s;
    logic [2:0] rate_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: spikes of the open window, plus expected outputs.
    bit win_q[$];
    bit exp_valid = 1'b0;
    bit exp_ovr   = 1'b0;
    int exp_raw   = 0;
    int exp_ttfs  = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spike(spike), .window(window),
        .rate_ready(rate_ready), .clear_overrun(clear_overrun),
        .rate_valid(rate_valid), .rate_count(rate_count), .rate_ttfs(rate_ttfs),
        .overrun(overrun)
    );

    spike_rate_decoder #(.WINDOW_W(8), .COUNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .spike(spike), .window(window),
        .rate_ready(rate_ready), .clear_overrun(clear_overrun),
        .rate_valid(rate_valid_s), .rate_count(rate_count_s), .rate_ttfs(rate_ttfs_s),
        .overrun(overrun_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_step();
        bit cap = 1'b0;
        int n = 0;
        int f = -1;
        if (reset) begin
            win_q.delete();
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            exp_raw   = 0;
            exp_ttfs  = 0;
            return;
        end
        if (!enable) begin
            win_q.delete();
        end else begin
            win_q.push_back(spike);
            if (win_q.size() - 1 >= int'(window)) begin
                cap = 1'b1;
                foreach (win_q[i]) begin
                    if (win_q[i]) begin
                        n++;
                        if (f < 0) f = i;
                    end
                end
                win_q.delete();
            end
        end
        if (cap) begin
            if (exp_valid && !rate_ready) exp_ovr = 1'b1;
            else if (clear_overrun)       exp_ovr = 1'b0;
            exp_valid = 1'b1;
            exp_raw   = n;
            exp_ttfs  = (f < 0) ? 255 : f;
        end else begin
            if (exp_valid && rate_ready) exp_valid = 1'b0;
            if (clear_overrun)           exp_ovr = 1'b0;
        end
    endtask

    task automatic cyc(input bit rst, input bit en, input bit sp, input int win,
                       input bit rdy, input bit clr);
        @(negedge clk);
        reset = rst; enable = en; spike = sp; window = 8'(win);
        rate_ready = rdy; clear_overrun = clr;
        @(posedge clk);
        model_step();
        #1;
        check("valid",   int'(rate_valid),   int'(exp_valid));
        check("overrun", int'(overrun),      int'(exp_ovr));
        check("count",   int'(rate_count),   sat(exp_raw, 255));
        check("ttfs",    int'(rate_ttfs),    exp_ttfs);
        check("valid_s", int'(rate_valid_s), int'(exp_valid));
        check("ovr_s",   int'(overrun_s),    int'(exp_ovr));
        check("count_s", int'(rate_count_s), sat(exp_raw, 7));
        check("ttfs_s",  int'(rate_ttfs_s),  exp_ttfs);
    endtask

    initial begin
        logic [7:0] pat;
        int         w;

        reset = 1'b1; enable = 1'b0; spike = 1'b0; window = '0;
        rate_ready = 1'b0; clear_overrun = 1'b0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_valid", int'(rate_valid), 0);
        check("rst_count", int'(rate_count), 0);
        check("rst_ttfs",  int'(rate_ttfs),  0);

        // window=7, spikes at 2,3,6
        pat = 8'b0100_1100;
        for (int i = 0; i < 8; i++) cyc(0, 1, pat[i], 7, 0, 0);
        check("w7_valid", int'(rate_valid), 1);
        check("w7_count", int'(rate_count), 3);
        check("w7_ttfs",  int'(rate_ttfs),  2);
        cyc(0, 1, 0, 7, 1, 0);
        cyc(0, 0, 0, 7, 1, 0);

        // window=3: empty window, then single spike at the last index
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 3, 0, 0);
        check("w3_empty_count", int'(rate_count), 0);
        check("w3_empty_ttfs",  int'(rate_ttfs),  255);
        for (int i = 0; i < 4; i++) cyc(0, 1, (i == 3), 3, 1, 0);
        check("w3_last_count", int'(rate_count), 1);
        check("w3_last_ttfs",  int'(rate_ttfs),  3);
        cyc(0, 0, 0, 3, 1, 1);

        // saturation: 16 spikes in a 16-cycle window
        for (int i = 0; i < 16; i++) cyc(0, 1, 1, 15, 0, 0);
        check("sat_count_s", int'(rate_count_s), 7);
        check("sat_count",   int'(rate_count),   16);
        check("sat_ttfs",    int'(rate_ttfs),    0);
        cyc(0, 0, 0, 15, 1, 0);

        // window=1, three unaccepted windows -> overrun
        for (int i = 0; i < 6; i++) cyc(0, 1, (i == 4), 1, 0, 0);
        check("ovr_set",   int'(overrun),    1);
        check("ovr_count", int'(rate_count), 1);
        check("ovr_ttfs",  int'(rate_ttfs),  0);
        cyc(0, 0, 0, 1, 0, 1);
        check("ovr_clr", int'(overrun), 0);
        cyc(0, 0, 0, 1, 1, 0);
        check("ready_drop", int'(rate_valid), 0);

        // window=0 with ready high: capture every cycle, no overrun
        for (int i = 0; i < 6; i++) cyc(0, 1, 1'($urandom_range(0, 1)), 0, 1, 0);
        check("w0_valid", int'(rate_valid), 1);
        check("w0_ovr",   int'(overrun),    0);
        cyc(0, 0, 0, 0, 1, 0);

        // enable dropped at index 4, then a fresh window
        for (int i = 0; i < 5; i++) cyc(0, 1, (i == 1), 7, 0, 0);
        cyc(0, 0, 0, 7, 0, 0);
        check("abort_novalid", int'(rate_valid), 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, (i == 5), 7, 0, 0);
        check("restart_ttfs", int'(rate_ttfs), 5);

        // reset mid-window with a pending result
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 7, 0, 0);
        cyc(1, 1, 1, 7, 0, 0);
        check("rst2_valid", int'(rate_valid), 0);
        check("rst2_count", int'(rate_count), 0);
        check("rst2_ttfs",  int'(rate_ttfs),  0);
        check("rst2_ovr",   int'(overrun),    0);

        // randomized traffic, including window changes mid-window
        w = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                : int'($urandom_range(0, 9));
            end
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) != 0),
                1'($urandom_range(0, 1)), w, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 14) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
